// File: rtl/ro_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : ro_sched_pkg                                               |
// | Description : Shared types and constants for the dual-engine readout     |
// |               trigger scheduler (state encoding, grant-select codes,     |
// |               default timing limits, busy-select helper).                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package ro_sched_pkg;

  // Scheduler states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    GAP  = 2'd3
  } state_t;

  // active_sel encodings
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_ADC1 = 2'b01;
  localparam logic [1:0] SEL_ADC2 = 2'b10;

  // Default limits
  localparam int TIMEOUT_DEF  = 1024;
  localparam int MAX_SKIP_DEF = 4;

  // Busy line of whichever engine currently holds the grant
  function automatic logic sel_busy(input logic [1:0] sel,
                                    input logic       busy1,
                                    input logic       busy2);
    logic b;
    b = 1'b0;
    if (sel == SEL_ADC1) b = busy1;
    else if (sel == SEL_ADC2) b = busy2;
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ro_pend_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ro_pend_counter                                            |
// | Description : Saturating up/down pending-request counter with a sticky   |
// |               overflow flag.                                             |
// |   TX_CLK   in  clock                                                     |
// |   rst      in  synchronous active-high reset                             |
// |   inc      in  add one request                                           |
// |   dec      in  remove one request (grant)                                |
// |   clr_ovf  in  clear sticky overflow (a same-cycle overflow wins)        |
// |   cnt      out current pending count                                     |
// |   ovf      out sticky: request dropped at saturation                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ro_pend_counter
  import ro_sched_pkg::*;
#(
  parameter int PEND_W = 4
) (
  input  logic              TX_CLK,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  input  logic              clr_ovf,
  output logic [PEND_W-1:0] cnt,
  output logic              ovf
);

  localparam logic [PEND_W-1:0] c_cnt_max = '1;

  logic [PEND_W-1:0] cnt_d, cnt_q;
  logic              ovf_d, ovf_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    // inc and dec together cancel, so saturation only matters for a lone inc
    if (inc && !dec) begin
      if (cnt_q == c_cnt_max) ovf_d = 1'b1;
      else                    cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc) begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge TX_CLK) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule
`default_nettype wire

// File: rtl/ro_trigger_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ro_trigger_sched                                           |
// | Description : Queues readout requests for the full-resolution (ADC1) and |
// |               1-bit (ADC2) engines and issues mutually exclusive start   |
// |               triggers with a guard gap, response timeout, starvation    |
// |               guard for ADC1 and completion counters.                    |
// |   TX_CLK/rst            clock, synchronous active-high reset             |
// |   enable                allow new grants                                 |
// |   req_full/req_1bit     one-cycle request pulses                         |
// |   gap_cycles            idle cycles after busy falls                     |
// |   clear_err             clear sticky flags                               |
// |   adc1_busy/adc2_busy   engine busy inputs                               |
// |   adc1/adc2_start_trigger  start outputs (never both high)              |
// |   active_sel            00 none, 01 ADC1, 10 ADC2                        |
// |   ro_done               completion pulse                                 |
// |   pend_full/pend_1bit   queued request counts                            |
// |   full_cnt/bit_cnt      completed readouts (wrapping)                    |
// |   ovf_full/ovf_1bit/timeout_err  sticky error flags                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ro_trigger_sched
  import ro_sched_pkg::*;
#(
  parameter int PEND_W   = 4,
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int MAX_SKIP = MAX_SKIP_DEF
) (
  input  logic              TX_CLK,
  input  logic              rst,
  input  logic              enable,
  input  logic              req_full,
  input  logic              req_1bit,
  input  logic [15:0]       gap_cycles,
  input  logic              clear_err,
  input  logic              adc1_busy,
  input  logic              adc2_busy,
  output logic              adc1_start_trigger,
  output logic              adc2_start_trigger,
  output logic [1:0]        active_sel,
  output logic              ro_done,
  output logic [PEND_W-1:0] pend_full,
  output logic [PEND_W-1:0] pend_1bit,
  output logic [31:0]       full_cnt,
  output logic [31:0]       bit_cnt,
  output logic              ovf_full,
  output logic              ovf_1bit,
  output logic              timeout_err
);

  localparam int c_tmo_w  = $clog2(TIMEOUT + 1);
  localparam int c_skip_w = $clog2(MAX_SKIP + 1);
  localparam logic [c_tmo_w-1:0]  c_tmo_last = c_tmo_w'(TIMEOUT - 1);
  localparam logic [c_skip_w-1:0] c_skip_max = c_skip_w'(MAX_SKIP);

  state_t              state_d, state_q;
  logic [1:0]          active_sel_d, active_sel_q;
  logic                adc1_trig_d, adc1_trig_q;
  logic                adc2_trig_d, adc2_trig_q;
  logic                ro_done_d, ro_done_q;
  logic [31:0]         full_cnt_d, full_cnt_q;
  logic [31:0]         bit_cnt_d, bit_cnt_q;
  logic                timeout_err_d, timeout_err_q;
  logic [c_tmo_w-1:0]  tmo_cnt_d, tmo_cnt_q;
  logic [15:0]         gap_cnt_d, gap_cnt_q;
  logic [c_skip_w-1:0] skip_d, skip_q;

  logic grant_full;
  logic grant_1bit;
  logic cur_busy;
  logic any_pend;

  ro_pend_counter #(.PEND_W(PEND_W)) u_pend_full (
    .TX_CLK  (TX_CLK),
    .rst     (rst),
    .inc     (req_full),
    .dec     (grant_full),
    .clr_ovf (clear_err),
    .cnt     (pend_full),
    .ovf     (ovf_full)
  );

  ro_pend_counter #(.PEND_W(PEND_W)) u_pend_1bit (
    .TX_CLK  (TX_CLK),
    .rst     (rst),
    .inc     (req_1bit),
    .dec     (grant_1bit),
    .clr_ovf (clear_err),
    .cnt     (pend_1bit),
    .ovf     (ovf_1bit)
  );

  assign cur_busy = sel_busy(active_sel_q, adc1_busy, adc2_busy);
  assign any_pend = (pend_full != '0) || (pend_1bit != '0);

  always_comb begin
    state_d       = state_q;
    active_sel_d  = active_sel_q;
    adc1_trig_d   = adc1_trig_q;
    adc2_trig_d   = adc2_trig_q;
    ro_done_d     = 1'b0;
    full_cnt_d    = full_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    timeout_err_d = timeout_err_q;
    tmo_cnt_d     = tmo_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    skip_d        = skip_q;
    grant_full    = 1'b0;
    grant_1bit    = 1'b0;

    // Clear first so a timeout in the same cycle re-sets the flag
    if (clear_err) timeout_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        // Any busy (even unsolicited) blocks a grant: the pins are shared
        if (enable && !adc1_busy && !adc2_busy && any_pend) begin
          if ((pend_full != '0) && ((pend_1bit == '0) || (skip_q == c_skip_max))) begin
            grant_full   = 1'b1;
            active_sel_d = SEL_ADC1;
            adc1_trig_d  = 1'b1;
            skip_d       = '0;
          end else begin
            grant_1bit   = 1'b1;
            active_sel_d = SEL_ADC2;
            adc2_trig_d  = 1'b1;
            // Count 1-bit grants that overtook a waiting full request
            if ((pend_full != '0) && (skip_q != c_skip_max)) skip_d = skip_q + 1'b1;
          end
          tmo_cnt_d = '0;
          state_d   = ARM;
        end
      end

      ARM: begin
        if (cur_busy) begin
          adc1_trig_d = 1'b0;
          adc2_trig_d = 1'b0;
          state_d     = RUN;
        end else if (tmo_cnt_q == c_tmo_last) begin
          // Engine never answered: abandon the grant without counting it
          adc1_trig_d   = 1'b0;
          adc2_trig_d   = 1'b0;
          active_sel_d  = SEL_NONE;
          timeout_err_d = 1'b1;
          gap_cnt_d     = gap_cycles;
          state_d       = GAP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      RUN: begin
        if (!cur_busy) begin
          ro_done_d = 1'b1;
          if (active_sel_q == SEL_ADC1) full_cnt_d = full_cnt_q + 32'd1;
          else                          bit_cnt_d  = bit_cnt_q + 32'd1;
          active_sel_d = SEL_NONE;
          gap_cnt_d    = gap_cycles;
          state_d      = GAP;
        end
      end

      GAP: begin
        if (gap_cnt_q == 16'd0) state_d = IDLE;
        else                    gap_cnt_d = gap_cnt_q - 16'd1;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge TX_CLK) begin
    if (rst) begin
      state_q       <= IDLE;
      active_sel_q  <= SEL_NONE;
      adc1_trig_q   <= 1'b0;
      adc2_trig_q   <= 1'b0;
      ro_done_q     <= 1'b0;
      full_cnt_q    <= 32'd0;
      bit_cnt_q     <= 32'd0;
      timeout_err_q <= 1'b0;
      tmo_cnt_q     <= '0;
      gap_cnt_q     <= 16'd0;
      skip_q        <= '0;
    end else begin
      state_q       <= state_d;
      active_sel_q  <= active_sel_d;
      adc1_trig_q   <= adc1_trig_d;
      adc2_trig_q   <= adc2_trig_d;
      ro_done_q     <= ro_done_d;
      full_cnt_q    <= full_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      timeout_err_q <= timeout_err_d;
      tmo_cnt_q     <= tmo_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      skip_q        <= skip_d;
    end
  end

  assign adc1_start_trigger = adc1_trig_q;
  assign adc2_start_trigger = adc2_trig_q;
  assign active_sel         = active_sel_q;
  assign ro_done            = ro_done_q;
  assign full_cnt           = full_cnt_q;
  assign bit_cnt            = bit_cnt_q;
  assign timeout_err        = timeout_err_q;

endmodule
`default_nettype wire
